sbus_master_ctrl: RTL and testbench

- Synthesizable bus-master front end for the synchronous read/write bus: rw, addressLines and a shared data bus.
- Accepts read/write requests from a client over a valid/ready handshake and buffers them in a small request FIFO.
- Issues each request as a bus transaction to the memory slave and returns read data on a response strobe.
- Sits directly upstream of the bus slave and replaces the behavioural task-driven master.

---
 rtl/sbus_master_ctrl_if.sv | 31 +++
 rtl/sbus_master_ctrl.sv | 135 +++++++++++++
 tb/tb_sbus_master_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sbus_master_ctrl_if.sv
`default_nettype none
// sbus_master_ctrl_if: client request/response handshake plus rw/address/data bus signals.
// Revision 1.0
interface sbus_master_ctrl_if #(
  parameter int Asize = 4,
  parameter int Dsize = 15
);
  logic           reqValid;
  logic           reqReady;
  logic           reqRw;
  logic [Asize:0] reqAddr;
  logic [Dsize:0] reqWdata;
  logic           rspValid;
  logic [Dsize:0] rspRdata;
  logic           rw;
  logic [Asize:0] addressLines;
  logic [Dsize:0] dataOut;
  logic           dataOe;
  logic [Dsize:0] dataIn;

  modport master (
    input  reqValid, reqRw, reqAddr, reqWdata, dataIn,
    output reqReady, rspValid, rspRdata, rw, addressLines, dataOut, dataOe
  );

  modport slave (
    output reqValid, reqRw, reqAddr, reqWdata, dataIn,
    input  reqReady, rspValid, rspRdata, rw, addressLines, dataOut, dataOe
  );
endinterface
`default_nettype wire

// File: rtl/sbus_master_ctrl.sv
`default_nettype none
// sbus_master_ctrl: valid/ready request FIFO feeding a registered rw/address/data bus master.
// Revision 1.0
module sbus_master_ctrl #(
  parameter int Asize  = 4,
  parameter int Dsize  = 15,
  parameter int Fdepth = 4
) (
  input  wire logic          clock,
  input  wire logic          reset,
  sbus_master_ctrl_if.master bus
);

  localparam int PTR_W = $clog2(Fdepth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(Fdepth);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             fifo_rw    [Fdepth];
  logic [Asize:0]   fifo_addr  [Fdepth];
  logic [Dsize:0]   fifo_wdata [Fdepth];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, empty;

  logic             rw_q, rw_nxt;
  logic             oe_q, oe_nxt;
  logic             rsp_valid_q, rsp_valid_nxt;
  logic [Asize:0]   addr_q, addr_nxt;
  logic [Dsize:0]   dout_q, dout_nxt;
  logic [Dsize:0]   rdata_q, rdata_nxt;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign empty        = (count == '0);
  assign bus.reqReady = ~reset & (count != FULL_CNT);
  assign push         = bus.reqValid & bus.reqReady;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rw[wr_ptr]    <= bus.reqRw;
      fifo_addr[wr_ptr]  <= bus.reqAddr;
      fifo_wdata[wr_ptr] <= bus.reqWdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Every state except RD_ADDR is a dispatch point: pop the head if one is waiting.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    rw_nxt        = 1'b0;
    oe_nxt        = 1'b0;
    addr_nxt      = addr_q;
    dout_nxt      = dout_q;
    rsp_valid_nxt = 1'b0;
    rdata_nxt     = rdata_q;
    case (state)
      RD_ADDR: state_nxt = RD_DATA;
      default: begin
        if (state == RD_DATA) begin
          rsp_valid_nxt = 1'b1;
          rdata_nxt     = bus.dataIn;
        end
        if (!empty) begin
          pop      = 1'b1;
          addr_nxt = fifo_addr[rd_ptr];
          if (fifo_rw[rd_ptr]) begin
            state_nxt = WRITE;
            rw_nxt    = 1'b1;
            oe_nxt    = 1'b1;
            dout_nxt  = fifo_wdata[rd_ptr];
          end else begin
            state_nxt = RD_ADDR;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rw_q        <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      rdata_q     <= '0;
    end else begin
      rw_q        <= rw_nxt;
      oe_q        <= oe_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      addr_q      <= addr_nxt;
      dout_q      <= dout_nxt;
      rdata_q     <= rdata_nxt;
    end
  end

  assign bus.rw           = rw_q;
  assign bus.dataOe       = oe_q;
  assign bus.addressLines = addr_q;
  assign bus.dataOut      = dout_q;
  assign bus.rspValid     = rsp_valid_q;
  assign bus.rspRdata     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sbus_master_ctrl.sv
`default_nettype none
// tb_sbus_master_ctrl: directed and random requests checked cycle by cycle against a transaction-schedule model.
// Revision 1.0
module tb_sbus_master_ctrl;

  localparam int Asize  = 4;
  localparam int Dsize  = 15;
  localparam int Fdepth = 4;
  localparam int AW     = Asize + 1;
  localparam int DW     = Dsize + 1;
  localparam int MEM_N  = 2 ** AW;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sbus_master_ctrl_if #(.Asize(Asize), .Dsize(Dsize)) bus ();

  sbus_master_ctrl #(.Asize(Asize), .Dsize(Dsize), .Fdepth(Fdepth)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
    end
  endtask

  // Power-on memory contents shared by the slave and the reference.
  logic [DW-1:0] init_val [MEM_N];
  initial for (int i = 0; i < MEM_N; i++) init_val[i] = DW'($urandom);

  // Slave: captures driven writes, otherwise returns memory onto the resolved bus.
  logic [DW-1:0] slave_mem [MEM_N];
  bit            slave_wr  [MEM_N];
  always @(posedge clock) begin
    if (bus.rw && bus.dataOe) begin
      slave_mem[bus.addressLines] <= bus.dataOut;
      slave_wr[bus.addressLines]  <= 1'b1;
    end
  end
  assign bus.dataIn = bus.dataOe ? bus.dataOut :
                      (slave_wr[bus.addressLines] ? slave_mem[bus.addressLines] : init_val[bus.addressLines]);

  // Reference: requests wait in a queue; each starts at max(accept+1, previous end), writes cost 1, reads 2.
  req_t          pend[$];
  logic [DW-1:0] ref_mem [MEM_N];
  bit            ref_wr  [MEM_N];
  req_t          cur;
  bit            cur_valid  = 1'b0;
  int            cur_start  = 0;
  int            busy_until = 0;
  int            cyc        = 0;
  int            rsp_edge   = -1;
  logic [AW-1:0] rsp_addr   = '0;
  logic [AW-1:0] exp_addr   = '0;
  logic [DW-1:0] exp_dout   = '0;
  logic [DW-1:0] exp_rdata  = '0;
  bit            exp_ready  = 1'b1;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val[a];
  endfunction

  always @(posedge clock) begin : model
    bit   in_v;
    req_t in_req;
    bit   exp_we;
    bit   exp_rsp;
    if (reset) begin
      pend.delete();
      cur_valid  = 1'b0;
      busy_until = 0;
      cyc        = 0;
      rsp_edge   = -1;
      exp_addr   = '0;
      exp_dout   = '0;
      exp_rdata  = '0;
      exp_ready  = 1'b1;
    end else begin
      in_v   = bus.reqValid && exp_ready;
      in_req = '{rw: bus.reqRw, addr: bus.reqAddr, wdata: bus.reqWdata};
      #1;
      cyc++;
      exp_rsp = (rsp_edge == cyc);
      if (exp_rsp) exp_rdata = ref_rd(rsp_addr);
      if (cyc >= busy_until && pend.size() > 0) begin
        cur        = pend.pop_front();
        cur_valid  = 1'b1;
        cur_start  = cyc;
        busy_until = cyc + (cur.rw ? 1 : 2);
        exp_addr   = cur.addr;
        if (cur.rw) begin
          exp_dout          = cur.wdata;
          ref_mem[cur.addr] = cur.wdata;
          ref_wr[cur.addr]  = 1'b1;
        end else begin
          rsp_edge = cyc + 2;
          rsp_addr = cur.addr;
        end
      end
      if (in_v) pend.push_back(in_req);
      exp_ready = (pend.size() != Fdepth);
      exp_we    = cur_valid && cur.rw && (cyc == cur_start);
      check_eq("reqReady",     32'(bus.reqReady),     32'(exp_ready));
      check_eq("rw",           32'(bus.rw),           32'(exp_we));
      check_eq("dataOe",       32'(bus.dataOe),       32'(exp_we));
      check_eq("addressLines", 32'(bus.addressLines), 32'(exp_addr));
      check_eq("dataOut",      32'(bus.dataOut),      32'(exp_dout));
      check_eq("rspValid",     32'(bus.rspValid),     32'(exp_rsp));
      check_eq("rspRdata",     32'(bus.rspRdata),     32'(exp_rdata));
    end
  end

  task automatic drive(input bit v, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    bus.reqValid = v;
    bus.reqRw    = rw;
    bus.reqAddr  = a;
    bus.reqWdata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      idle(1);
      done = (pend.size() == 0) && (cyc >= busy_until) && (rsp_edge < cyc);
    end
    check_eq("drain", 32'(done), 32'd1);
  endtask

  // Reset lands mid-cycle so that only the asynchronous path can clear the outputs.
  task automatic apply_reset();
    @(negedge clock);
    #2;
    reset        = 1'b1;
    bus.reqValid = 1'b0;
    #1;
    check_eq("rst_reqReady", 32'(bus.reqReady),     32'd0);
    check_eq("rst_rw",       32'(bus.rw),           32'd0);
    check_eq("rst_dataOe",   32'(bus.dataOe),       32'd0);
    check_eq("rst_addr",     32'(bus.addressLines), 32'd0);
    check_eq("rst_dataOut",  32'(bus.dataOut),      32'd0);
    check_eq("rst_rspValid", 32'(bus.rspValid),     32'd0);
    check_eq("rst_rspRdata", 32'(bus.rspRdata),     32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rel_reqReady", 32'(bus.reqReady), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit;
    bus.reqValid = 1'b0;
    bus.reqRw    = 1'b0;
    bus.reqAddr  = '0;
    bus.reqWdata = '0;
    apply_reset();

    // Single write, then read it back.
    drive(1'b1, 1'b1, AW'(2), DW'(5));
    idle(4);
    drive(1'b1, 1'b0, AW'(2), DW'(0));
    idle(5);

    // Burst W(2,5) W(3,7) R(2) R(3).
    drive(1'b1, 1'b1, AW'(2), DW'(5));
    drive(1'b1, 1'b1, AW'(3), DW'(7));
    drive(1'b1, 1'b0, AW'(2), DW'($urandom));
    drive(1'b1, 1'b0, AW'(3), DW'($urandom));
    drain();

    // Six back-to-back reads: reaches a push and pop together at count 3.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, AW'(i), DW'($urandom));
    drain();

    // Hold valid long enough to fill the FIFO and wrap the pointers.
    for (int i = 0; i < 12; i++) drive(1'b1, 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
    drain();

    // Reset during the data phase of a read with two writes queued behind it.
    drive(1'b1, 1'b0, AW'(2), DW'(0));
    drive(1'b1, 1'b1, AW'(9), DW'(16'h1111));
    drive(1'b1, 1'b1, AW'(10), DW'(16'h2222));
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      idle(1);
      hit = cur_valid && !cur.rw && (cyc - cur_start == 1) && (pend.size() == 2);
    end
    check_eq("rst_window", 32'(hit), 32'd1);
    apply_reset();
    idle(4);
    drain();

    // Random traffic over a small address range so reads observe earlier writes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
